// File: rtl/counter_load_sequencer.sv
// counter_load_sequencer: FIFO-buffered preset loader issuing spaced load pulses; COUNTER_LOAD_SEQ_LEVEL_EN adds fill_level
module counter_load_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [WIDTH-1:0]         req_data,
  output logic                     req_ready,
  input  logic                     seq_en,
  input  logic                     flush,
  output logic                     load,
  output logic [WIDTH-1:0]         load_data,
`ifdef COUNTER_LOAD_SEQ_LEVEL_EN
  output logic [$clog2(DEPTH):0]   fill_level,
`endif
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef enum logic {S_IDLE, S_GAP} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic empty, full, push, issue;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign req_ready = !full && !flush;
  assign push = req_valid && req_ready;
  assign busy = !empty || state == S_GAP || load;
`ifdef COUNTER_LOAD_SEQ_LEVEL_EN
  assign fill_level = wptr - rptr;
`endif
  // state and gap counter registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  // next state: flush wins, an issue arms the gap, the gap counts down to idle
  always_comb begin
    state_nxt = state;
    gap_nxt = gap_cnt;
    if (flush) begin
      state_nxt = S_IDLE;
      gap_nxt = '0;
    end else if (issue) begin
      state_nxt = GAP > 0 ? S_GAP : S_IDLE;
      gap_nxt = GW'(GAP);
    end else if (state == S_GAP) begin
      state_nxt = gap_cnt == GW'(1) ? S_IDLE : S_GAP;
      gap_nxt = gap_cnt - 1'b1;
    end
  end
  // issue decode: pop the head and pulse load when idle, enabled and not flushing
  always_comb begin
    issue = state == S_IDLE && seq_en && !empty && !flush;
  end
  // registered load outputs and FIFO pointers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      load <= 1'b0;
      load_data <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      load <= issue;
      if (issue) load_data <= mem[rptr[AW-1:0]];
      wptr <= flush ? '0 : wptr + (AW+1)'(push);
      rptr <= flush ? '0 : rptr + (AW+1)'(issue);
    end
  // FIFO storage
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= req_data;
endmodule
